// File: rtl/pll_reset_sequencer.sv
// PLL power-up / lock-supervision sequencer: drives pll_rst and derives a clean
// system reset from the asynchronous PLL lock indicator.
module pll_reset_sequencer #(
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int SETTLE_CYCLES       = 1024,
    parameter int CNT_W               = 20,
    parameter int RETRY_W             = 4
) (
    input  logic               refclk,
    input  logic               rst_n,
    input  logic               locked,
    output logic               pll_rst,
    output logic               sys_rst,
    output logic               ready,
    output logic [RETRY_W-1:0] retry_count
);

    typedef enum logic [1:0] {PLL_RESET, WAIT_LOCK, SETTLE, RUN} state_t;

    localparam logic [CNT_W-1:0] PLL_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    logic [1:0]       rst_sync;
    logic             rst_i_n;
    logic [1:0]       lock_sync;
    logic             lock_s;
    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             retry_inc;

    // Assert asynchronously, release after two refclk edges.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_i_n = rst_sync[1];

    always_ff @(posedge refclk or negedge rst_i_n) begin
        if (!rst_i_n) lock_sync <= 2'b00;
        else          lock_sync <= {lock_sync[0], locked};
    end
    assign lock_s = lock_sync[1];

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt + CNT_W'(1);
        retry_inc = 1'b0;
        case (state)
            PLL_RESET: if (cnt == PLL_LAST) state_nx = WAIT_LOCK;
            // Lock arriving on the timeout cycle takes priority over a retry.
            WAIT_LOCK: begin
                if (lock_s) state_nx = SETTLE;
                else if (cnt == TIMEOUT_LAST) begin
                    state_nx  = PLL_RESET;
                    retry_inc = 1'b1;
                end
            end
            SETTLE: begin
                if (!lock_s) state_nx = WAIT_LOCK;
                else if (cnt == SETTLE_LAST) state_nx = RUN;
            end
            RUN: begin
                if (!lock_s) begin
                    state_nx  = PLL_RESET;
                    retry_inc = 1'b1;
                end
            end
            default: state_nx = PLL_RESET;
        endcase
        if (state_nx != state) cnt_nx = '0;
    end

    // Outputs decode the next state so they move on the same edge as the state.
    always_ff @(posedge refclk or negedge rst_i_n) begin
        if (!rst_i_n) begin
            state       <= PLL_RESET;
            cnt         <= '0;
            pll_rst     <= 1'b1;
            sys_rst     <= 1'b1;
            ready       <= 1'b0;
            retry_count <= '0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            pll_rst <= (state_nx == PLL_RESET);
            sys_rst <= (state_nx != RUN);
            ready   <= (state_nx == RUN);
            if (retry_inc && (retry_count != '1))
                retry_count <= retry_count + RETRY_W'(1);
        end
    end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench: a phase-level model predicts every output transition from
// the locked waveform; a negedge monitor pops and compares each observed change.
module tb_pll_reset_sequencer;

    localparam int PLL = 4, TO = 20, SET = 8, RW = 2;
    localparam int RMAX = (1 << RW) - 1;
    localparam int HALF = 5;

    logic          refclk = 1'b0;
    logic          rst_n  = 1'b0;
    logic          locked = 1'b0;
    logic          pll_rst, sys_rst, ready;
    logic [RW-1:0] retry_count;

    pll_reset_sequencer #(
        .PLL_RST_CYCLES(PLL), .LOCK_TIMEOUT_CYCLES(TO), .SETTLE_CYCLES(SET),
        .CNT_W(8), .RETRY_W(RW)
    ) dut (
        .refclk(refclk), .rst_n(rst_n), .locked(locked),
        .pll_rst(pll_rst), .sys_rst(sys_rst), .ready(ready),
        .retry_count(retry_count)
    );

    always #HALF refclk = ~refclk;

    typedef struct {
        int         cyc;
        logic [4:0] v;   // {pll_rst, sys_rst, ready, retry_count}
    } ev_t;

    ev_t        q[$];
    bit         lk[0:1023];   // locked value driven just after edge k
    int         cyc;
    int         n_vec = 0, n_err = 0;
    bit         mon_en = 0;
    logic [4:0] prev, cur;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // Lock level the sequencer acts on at edge c: the driven value three edges back.
    function automatic bit seen(int c);
        return (c >= 5) ? lk[c-3] : 1'b0;
    endfunction

    // First edge in [a,b] where the acted-on lock equals v; -1 none, -2 past horizon.
    function automatic int first(bit v, int a, int b, int n);
        for (int i = a; i <= b; i++) begin
            if (i > n) return -2;
            if (seen(i) == v) return i;
        end
        return -1;
    endfunction

    function automatic void push(int c, bit p, bit s, int rc, int n);
        ev_t e;
        if (c > n) return;
        e.cyc = c;
        e.v   = {p, s, ~s, 2'(rc)};
        q.push_back(e);
    endfunction

    function automatic void build_model(int n);
        int t = 2, rc = 0, w, c, d, r;
        forever begin
            w = t + PLL;
            if (w > n) return;
            push(w, 0, 1, rc, n);
            forever begin
                c = first(1, w + 1, w + TO, n);
                if (c == -2) return;
                if (c == -1) begin
                    t  = w + TO;
                    rc = (rc < RMAX) ? rc + 1 : RMAX;
                    push(t, 1, 1, rc, n);
                    break;
                end
                d = first(0, c + 1, c + SET, n);
                if (d == -2) return;
                if (d >= 0) begin
                    w = d;
                    continue;
                end
                r = c + SET;
                push(r, 0, 0, rc, n);
                d = first(0, r + 1, n, n);
                if (d < 0) return;
                t  = d;
                rc = (rc < RMAX) ? rc + 1 : RMAX;
                push(t, 1, 1, rc, n);
                break;
            end
        end
    endfunction

    always @(negedge refclk) begin
        if (mon_en) begin
            cur = {pll_rst, sys_rst, ready, retry_count};
            if (cur !== prev) begin
                if (q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_change: got %b expected %b (cycle %0d)", cur, prev, cyc);
                end else begin
                    ev_t e;
                    e = q.pop_front();
                    chk("evt_cycle", cyc, e.cyc);
                    chk("evt_value", cur, e.v);
                end
                prev = cur;
            end
        end
    end

    function automatic void lk_fill(int a, int b, bit v);
        for (int k = a; k <= b; k++) lk[k] = v;
    endfunction

    task automatic session(int n, bit async_rst);
        @(posedge refclk);
        #1 rst_n = 1'b0;
        locked = 1'b0;
        repeat (3) @(posedge refclk);
        #1;
        chk("rst_pll_rst", pll_rst, 1);
        chk("rst_sys_rst", sys_rst, 1);
        chk("rst_ready", ready, 0);
        chk("rst_retry", retry_count, 0);
        q.delete();
        build_model(n);
        prev   = 5'b11000;
        cyc    = 0;
        rst_n  = 1'b1;
        locked = lk[0];
        mon_en = 1;
        while (cyc < n) begin
            @(posedge refclk);
            cyc++;
            #1 locked = lk[cyc];
        end
        @(negedge refclk);
        #2;
        mon_en = 0;
        chk("queue_drained", q.size(), 0);
        if (async_rst) begin
            rst_n = 1'b0;
            #1;
            chk("async_pll_rst", pll_rst, 1);
            chk("async_sys_rst", sys_rst, 1);
            chk("async_ready", ready, 0);
            chk("async_retry", retry_count, 0);
        end
    endtask

    initial begin
        // normal lock, loss in RUN, relock
        lk_fill(0, 1023, 0); lk_fill(11, 39, 1); lk_fill(55, 1023, 1);
        session(90, 0);
        // lock never arrives: retries saturate
        lk_fill(0, 1023, 0);
        session(130, 0);
        // two-cycle low glitch while settling
        lk_fill(0, 1023, 0); lk_fill(11, 15, 1); lk_fill(18, 1023, 1);
        session(50, 0);
        // lock seen exactly on the timeout cycle, then one cycle too late
        lk_fill(0, 1023, 0); lk_fill(23, 1023, 1);
        session(50, 0);
        lk_fill(0, 1023, 0); lk_fill(24, 1023, 1);
        session(70, 0);
        // one retry, then async reset while settling
        lk_fill(0, 1023, 0); lk_fill(40, 1023, 1);
        session(46, 1);
        // random lock waveforms
        for (int s = 0; s < 10; s++) begin
            int  k = 0;
            bit  v = 0;
            while (k <= 1023) begin
                int len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                                      : int'($urandom_range(4, 60));
                for (int j = 0; j < len && k <= 1023; j++) begin
                    lk[k] = v;
                    k++;
                end
                v = !v;
            end
            session(400, 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
